// File: rtl/mem_initiator_pkg.sv
// Shared widths and memory-operation encodings for the KV10 memory initiator.
package mem_initiator_pkg;
    localparam int WORD          = 36;
    localparam int PADDRSIZE     = 22;
    localparam int WATCHDOG_BITS = 10;

    typedef enum logic [1:0] {
        MEM_OP_READ  = 2'b00,
        MEM_OP_WRITE = 2'b01,
        MEM_OP_RMW   = 2'b10,
        MEM_OP_RSVD  = 2'b11
    } mem_op_e;
endpackage

// File: rtl/mem_initiator_watchdog.sv
// Down-counting acknowledge watchdog; expired flags a held request whose count reached zero.
module mem_watchdog
    import mem_initiator_pkg::*;
(
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     load,
    input  logic                     run,
    input  logic [WATCHDOG_BITS-1:0] load_value,
    output logic                     expired
);

    logic [WATCHDOG_BITS-1:0] r_count;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
        end else if (load) begin
            r_count <= load_value;
        end else if (run && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign expired = run && (r_count == '0);

endmodule

// File: rtl/mem_initiator.sv
// Bus-master side of the KV10 memory handshake: READ, WRITE and PDP-10 read-modify-write
// with held request levels and a watchdog that turns a missing acknowledge into NXM.
module mem_initiator
    import mem_initiator_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 cpu_req,
    input  logic [1:0]           cpu_op,
    input  logic [PADDRSIZE-1:0] cpu_addr,
    input  logic [WORD-1:0]      cpu_wdata,
    input  logic                 cpu_wb,
    output logic                 cpu_ready,
    output logic                 cpu_done,
    output logic [WORD-1:0]      cpu_rdata,
    output logic                 cpu_nxm,
    output logic [PADDRSIZE-1:0] mem_addr,
    output logic [WORD-1:0]      mem_write_data,
    output logic                 mem_read,
    output logic                 mem_write,
    input  logic [WORD-1:0]      mem_read_data,
    input  logic                 read_ack,
    input  logic                 write_ack,
    input  logic                 nxm
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_WR,
        S_RMW_RD,
        S_RMW_HOLD,
        S_RMW_WR
    } state_e;

    localparam logic [WATCHDOG_BITS-1:0] WD_LOAD = WATCHDOG_BITS'(TIMEOUT);

    state_e                 r_state, w_state_nx;
    logic [PADDRSIZE-1:0]   r_mem_addr, w_mem_addr_nx;
    logic [WORD-1:0]        r_mem_wdata, w_mem_wdata_nx;
    logic [WORD-1:0]        r_cpu_rdata, w_cpu_rdata_nx;
    logic                   r_mem_read, w_mem_read_nx;
    logic                   r_mem_write, w_mem_write_nx;
    logic                   r_cpu_done, w_cpu_done_nx;
    logic                   r_cpu_nxm, w_cpu_nxm_nx;
    logic                   r_cpu_ready, w_cpu_ready_nx;
    logic                   w_wd_load, w_wd_run, w_expired;

    // The watchdog only counts while a request level is actually on the bus.
    assign w_wd_run = (r_state == S_RD) || (r_state == S_WR) ||
                      (r_state == S_RMW_RD) || (r_state == S_RMW_WR);

    mem_watchdog u_watchdog (
        .clk        (clk),
        .reset      (reset),
        .load       (w_wd_load),
        .run        (w_wd_run),
        .load_value (WD_LOAD),
        .expired    (w_expired)
    );

    always_comb begin
        w_state_nx     = r_state;
        w_mem_addr_nx  = r_mem_addr;
        w_mem_wdata_nx = r_mem_wdata;
        w_cpu_rdata_nx = r_cpu_rdata;
        w_mem_read_nx  = r_mem_read;
        w_mem_write_nx = r_mem_write;
        w_cpu_done_nx  = 1'b0;
        w_cpu_nxm_nx   = 1'b0;
        w_wd_load      = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (cpu_req && r_cpu_ready) begin
                    w_mem_addr_nx  = cpu_addr;
                    w_mem_wdata_nx = cpu_wdata;
                    case (mem_op_e'(cpu_op))
                        MEM_OP_READ: begin
                            w_state_nx    = S_RD;
                            w_mem_read_nx = 1'b1;
                            w_wd_load     = 1'b1;
                        end
                        MEM_OP_WRITE: begin
                            w_state_nx     = S_WR;
                            w_mem_write_nx = 1'b1;
                            w_wd_load      = 1'b1;
                        end
                        MEM_OP_RMW: begin
                            w_state_nx    = S_RMW_RD;
                            w_mem_read_nx = 1'b1;
                            w_wd_load     = 1'b1;
                        end
                        default: begin
                            w_cpu_done_nx = 1'b1;
                            w_cpu_nxm_nx  = 1'b1;
                        end
                    endcase
                end
            end
            // nxm outranks a coincident acknowledge; wrong-kind acks fall through unseen.
            S_RD, S_RMW_RD: begin
                if (nxm || (w_expired && !read_ack)) begin
                    w_mem_read_nx = 1'b0;
                    w_cpu_done_nx = 1'b1;
                    w_cpu_nxm_nx  = 1'b1;
                    w_state_nx    = S_IDLE;
                end else if (read_ack) begin
                    w_mem_read_nx  = 1'b0;
                    w_cpu_rdata_nx = mem_read_data;
                    w_cpu_done_nx  = 1'b1;
                    w_state_nx     = (r_state == S_RD) ? S_IDLE : S_RMW_HOLD;
                end
            end
            S_WR, S_RMW_WR: begin
                if (nxm || (w_expired && !write_ack)) begin
                    w_mem_write_nx = 1'b0;
                    w_cpu_done_nx  = 1'b1;
                    w_cpu_nxm_nx   = 1'b1;
                    w_state_nx     = S_IDLE;
                end else if (write_ack) begin
                    w_mem_write_nx = 1'b0;
                    w_cpu_done_nx  = 1'b1;
                    w_state_nx     = S_IDLE;
                end
            end
            S_RMW_HOLD: begin
                if (cpu_wb) begin
                    w_mem_wdata_nx = cpu_wdata;
                    w_mem_write_nx = 1'b1;
                    w_wd_load      = 1'b1;
                    w_state_nx     = S_RMW_WR;
                end
            end
            default: begin
                w_state_nx     = S_IDLE;
                w_mem_read_nx  = 1'b0;
                w_mem_write_nx = 1'b0;
            end
        endcase

        w_cpu_ready_nx = (w_state_nx == S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_cpu_rdata <= '0;
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
            r_cpu_done  <= 1'b0;
            r_cpu_nxm   <= 1'b0;
            r_cpu_ready <= 1'b1;
        end else begin
            r_state     <= w_state_nx;
            r_mem_addr  <= w_mem_addr_nx;
            r_mem_wdata <= w_mem_wdata_nx;
            r_cpu_rdata <= w_cpu_rdata_nx;
            r_mem_read  <= w_mem_read_nx;
            r_mem_write <= w_mem_write_nx;
            r_cpu_done  <= w_cpu_done_nx;
            r_cpu_nxm   <= w_cpu_nxm_nx;
            r_cpu_ready <= w_cpu_ready_nx;
        end
    end

    assign cpu_ready      = r_cpu_ready;
    assign cpu_done       = r_cpu_done;
    assign cpu_rdata      = r_cpu_rdata;
    assign cpu_nxm        = r_cpu_nxm;
    assign mem_addr       = r_mem_addr;
    assign mem_write_data = r_mem_wdata;
    assign mem_read       = r_mem_read;
    assign mem_write      = r_mem_write;

endmodule

// File: tb/tb_mem_initiator.sv
// Directed bench for mem_initiator against a small responder model with selectable wait/fault modes.
module tb_mem_initiator;
    import mem_initiator_pkg::*;

    localparam int TO = 8;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 cpu_req;
    logic [1:0]           cpu_op;
    logic [PADDRSIZE-1:0] cpu_addr;
    logic [WORD-1:0]      cpu_wdata;
    logic                 cpu_wb;
    logic                 cpu_ready, cpu_done, cpu_nxm;
    logic [WORD-1:0]      cpu_rdata;
    logic [PADDRSIZE-1:0] mem_addr;
    logic [WORD-1:0]      mem_write_data;
    logic                 mem_read, mem_write;
    logic [WORD-1:0]      mem_read_data = '0;
    logic                 read_ack, write_ack;
    logic                 r_rack = 1'b0, r_wack = 1'b0, r_nxm = 1'b0, inj_rack = 1'b0;

    always #5 clk = ~clk;

    mem_initiator #(.TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .cpu_req(cpu_req), .cpu_op(cpu_op),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_wb(cpu_wb),
        .cpu_ready(cpu_ready), .cpu_done(cpu_done), .cpu_rdata(cpu_rdata),
        .cpu_nxm(cpu_nxm), .mem_addr(mem_addr), .mem_write_data(mem_write_data),
        .mem_read(mem_read), .mem_write(mem_write), .mem_read_data(mem_read_data),
        .read_ack(read_ack), .write_ack(write_ack), .nxm(r_nxm)
    );

    assign read_ack  = r_rack | inj_rack;
    assign write_ack = r_wack;

    // Responder model: mode 0 acks after resp_wait extra cycles, 1 never acks, 2 answers reads with nxm.
    // Storage decodes only address bits 11:9, enough for the addresses used here.
    logic [WORD-1:0] mem [0:7];
    int resp_wait = 0;
    int resp_mode = 0;
    int wcnt = 0;

    always @(posedge clk) begin
        r_rack <= 1'b0;
        r_wack <= 1'b0;
        r_nxm  <= 1'b0;
        if (reset) begin
            wcnt <= 0;
        end else if ((mem_read || mem_write) && !r_rack && !r_wack && !r_nxm && resp_mode != 1) begin
            if (wcnt == resp_wait) begin
                wcnt <= 0;
                if (mem_read && resp_mode == 2) begin
                    r_nxm <= 1'b1;
                end else if (mem_read) begin
                    r_rack        <= 1'b1;
                    mem_read_data <= mem[mem_addr[11:9]];
                end else begin
                    r_wack               <= 1'b1;
                    mem[mem_addr[11:9]]  <= mem_write_data;
                end
            end else begin
                wcnt <= wcnt + 1;
            end
        end else begin
            wcnt <= 0;
        end
    end

    // Bus protocol monitors
    int   overlap = 0;
    int   gapv    = 0;
    logic prev_ack = 1'b0;
    logic wr_seen  = 1'b0;

    always @(negedge clk) begin
        if (mem_read && mem_write) overlap = overlap + 1;
        if (prev_ack && (mem_read || mem_write)) gapv = gapv + 1;
        if (mem_write) wr_seen = 1'b1;
        prev_ack = read_ack || write_ack || r_nxm;
    end

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0o expected=%0o", tag, got, exp);
        end
    endtask

    task automatic wait_done(output int lat, output logic nx, output logic [WORD-1:0] rd);
        lat = -1;
        nx  = 1'b0;
        rd  = cpu_rdata;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (cpu_done) begin
                lat = k;
                nx  = cpu_nxm;
                rd  = cpu_rdata;
                break;
            end
        end
        if (lat < 0) chk("done_timeout", 64'd0, 64'd1);
    endtask

    // Called at a negedge; returns at the negedge following the cycle cpu_done is seen.
    task automatic access(input logic [1:0] op, input logic [PADDRSIZE-1:0] addr,
                          input logic [WORD-1:0] wd, output int lat, output logic nx,
                          output logic [WORD-1:0] rd);
        cpu_req   = 1'b1;
        cpu_op    = op;
        cpu_addr  = addr;
        cpu_wdata = wd;
        @(negedge clk);
        cpu_req = 1'b0;
        if (cpu_done) begin
            lat = 0;
            nx  = cpu_nxm;
            rd  = cpu_rdata;
        end else begin
            wait_done(lat, nx, rd);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got=running expected=finished");
        $fatal(1, "simulation time limit");
    end

    int              lat;
    logic            nx;
    logic [WORD-1:0] rd;
    int              errs;

    initial begin
        for (int i = 0; i < 8; i++) mem[i] = '0;
        mem[1] = 36'o123456701234;
        mem[3] = 36'd5;
        reset = 1'b1; cpu_req = 1'b0; cpu_op = 2'b00; cpu_addr = '0; cpu_wdata = '0; cpu_wb = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_ready", cpu_ready, 1);
        chk("rst_req", {mem_read, mem_write}, 0);
        chk("rst_done", {cpu_done, cpu_nxm}, 0);
        chk("rst_addr", mem_addr, 0);
        reset = 1'b0;
        @(negedge clk);

        // Zero-wait READ, cycle by cycle
        cpu_req = 1'b1; cpu_op = 2'b00; cpu_addr = 22'o1000;
        @(negedge clk);
        cpu_req = 1'b0;
        chk("rd_E_read", mem_read, 1);
        chk("rd_E_ready", cpu_ready, 0);
        chk("rd_E_addr", mem_addr, 22'o1000);
        @(negedge clk);
        chk("rd_E1_read", mem_read, 1);
        chk("rd_E1_done", cpu_done, 0);
        @(negedge clk);
        chk("rd_E2_read", mem_read, 0);
        chk("rd_E2_done", {cpu_done, cpu_nxm}, 2'b10);
        chk("rd_E2_data", cpu_rdata, 36'o123456701234);
        @(negedge clk);
        chk("rd_E3_done", cpu_done, 0);
        chk("rd_E3_ready", cpu_ready, 1);

        // Back-to-back READs, then WRITE/READ round trip
        access(2'b00, 22'o1000, '0, lat, nx, rd);
        chk("b2b_lat0", lat, 2);
        access(2'b00, 22'o1000, '0, lat, nx, rd);
        chk("b2b_lat1", lat, 2);
        access(2'b01, 22'o2000, 36'o777777777777, lat, nx, rd);
        chk("wr_lat", lat, 2);
        chk("wr_nxm", nx, 0);
        access(2'b00, 22'o2000, '0, lat, nx, rd);
        chk("wr_rd_data", rd, 36'o777777777777);
        chk("overlap1", overlap, 0);
        chk("gap1", gapv, 0);

        // Reserved op completes on the accept edge with an error
        access(2'b11, 22'o1000, '0, lat, nx, rd);
        chk("rsvd_lat", lat, 0);
        chk("rsvd_nxm", nx, 1);
        chk("rsvd_noreq", {mem_read, mem_write}, 0);
        @(negedge clk);
        chk("rsvd_pulse", {cpu_done, cpu_nxm}, 0);

        // RMW with a 4-cycle hold before write-back
        access(2'b10, 22'o3000, '0, lat, nx, rd);
        chk("rmw_rd_lat", lat, 2);
        chk("rmw_rd_data", rd, 5);
        errs = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (cpu_ready || mem_read || mem_write || cpu_done || mem_addr != 22'o3000) errs++;
        end
        chk("rmw_hold", errs, 0);
        cpu_wb = 1'b1; cpu_wdata = 36'd6;
        @(negedge clk);
        cpu_wb = 1'b0;
        chk("rmw_wr_level", {mem_read, mem_write}, 2'b01);
        chk("rmw_wr_addr", mem_addr, 22'o3000);
        chk("rmw_wr_data", mem_write_data, 6);
        wait_done(lat, nx, rd);
        chk("rmw_wr_lat", lat, 2);
        chk("rmw_wr_nxm", nx, 0);
        access(2'b00, 22'o3000, '0, lat, nx, rd);
        chk("rmw_final", rd, 6);

        // No acknowledge: watchdog fires TIMEOUT+1 edges after accept
        resp_mode = 1;
        cpu_req = 1'b1; cpu_op = 2'b00; cpu_addr = 22'o4000;
        @(negedge clk);
        cpu_req = 1'b0;
        errs = 0;
        for (int k = 1; k <= TO; k++) begin
            @(negedge clk);
            if (cpu_done || !mem_read) errs++;
        end
        chk("to_early", errs, 0);
        @(negedge clk);
        chk("to_fire", {cpu_done, cpu_nxm}, 2'b11);
        chk("to_drop", mem_read, 0);
        resp_mode = 0;
        inj_rack = 1'b1;
        @(negedge clk);
        inj_rack = 1'b0;
        chk("late_ack_done", {cpu_done, cpu_nxm}, 0);
        chk("late_ack_ready", cpu_ready, 1);
        chk("late_ack_rdata", cpu_rdata, 6);

        // nxm during RMW read phase abandons the write
        resp_mode = 2;
        wr_seen = 1'b0;
        access(2'b10, 22'o3000, '0, lat, nx, rd);
        chk("rmw_nxm", nx, 1);
        chk("rmw_nxm_ready", cpu_ready, 1);
        cpu_wb = 1'b1; cpu_wdata = 36'd7;
        repeat (3) @(negedge clk);
        cpu_wb = 1'b0;
        chk("rmw_nxm_nowrite", wr_seen, 0);
        resp_mode = 0;

        // Reset while a slow write is outstanding
        resp_wait = 3;
        cpu_req = 1'b1; cpu_op = 2'b01; cpu_addr = 22'o5000; cpu_wdata = 36'o1234;
        @(negedge clk);
        cpu_req = 1'b0;
        chk("rst_wr_level", mem_write, 1);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("rstwr_write", mem_write, 0);
        chk("rstwr_ready", cpu_ready, 1);
        chk("rstwr_pulses", {mem_read, cpu_done, cpu_nxm}, 0);
        chk("rstwr_addr", mem_addr, 0);
        chk("rstwr_wdata", mem_write_data, 0);
        chk("rstwr_rdata", cpu_rdata, 0);
        reset = 1'b0;
        resp_wait = 0;
        @(negedge clk);
        access(2'b00, 22'o1000, '0, lat, nx, rd);
        chk("post_rst_rd", rd, 36'o123456701234);
        chk("overlap_all", overlap, 0);
        chk("gap_all", gapv, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_initiator.md
# mem_initiator

Bus-master side of the synchronous memory handshake used by the KV10 memory responder. It accepts one CPU-side request at a time (read, write, or PDP-10 read-modify-write), drives `mem_read`/`mem_write` as held levels, and completes on `read_ack`, `write_ack` or `nxm`. A watchdog converts a missing acknowledge into a non-existent-memory error. It sits between the processor's memory-reference logic and the memory responder.

## Interface
Parameters:
- `TIMEOUT`, 255: cycles a memory request may stay asserted without acknowledge before it is failed as NXM; legal range 1..1023.

Ports:
- `clk`  in  1  sole clock; everything on posedge.
- `reset`  in  1  synchronous, active-high.
- `cpu_req`  in  1  request valid; accepted on an edge where `cpu_ready`=1.
- `cpu_op`  in  2  00 READ, 01 WRITE, 10 RMW, 11 reserved (accepted, completed immediately with `cpu_nxm`).
- `cpu_addr`  in  `PADDR`  physical address.
- `cpu_wdata`  in  `WORD`  write data for WRITE, and for the RMW write-back.
- `cpu_wb`  in  1  RMW write-back strobe; sampled only in state RMW_HOLD.
- `cpu_ready`  out  1  high only in IDLE.
- `cpu_done`  out  1  one-cycle pulse at the end of each access phase.
- `cpu_rdata`  out  `WORD`  read data; holds until the next read completes.
- `cpu_nxm`  out  1  one-cycle pulse, coincident with `cpu_done`, on error.
- `mem_addr`  out  `PADDR`  registered address.
- `mem_write_data`  out  `WORD`  registered write data.
- `mem_read`  out  1  read request level.
- `mem_write`  out  1  write request level. Never high together with `mem_read`.
- `mem_read_data`  in  `WORD`  valid in the cycle `read_ack`=1.
- `read_ack`, `write_ack`, `nxm`  in  1 each  one-cycle responder pulses.

## Operation
- States:
  - IDLE
  - RD
  - WR
  - RMW_RD
  - RMW_HOLD
  - RMW_WR
- IDLE, accept (`cpu_req` && `cpu_ready`):
  - Latch the address and write data into `mem_addr`/`mem_write_data`.
  - READ goes to RD and RMW goes to RMW_RD, each raising `mem_read`.
  - WRITE goes to WR, raising `mem_write`.
  - Load the watchdog with `TIMEOUT`.
- RD and RMW_RD:
  - On `read_ack`: drop `mem_read`, load `cpu_rdata` from `mem_read_data`, pulse `cpu_done`. RD goes to IDLE; RMW_RD goes to RMW_HOLD.
  - On `nxm`, or watchdog expiry: drop `mem_read` and pulse `cpu_done` + `cpu_nxm`. Go to IDLE; the write phase of an RMW is abandoned.
- WR and RMW_WR:
  - On `write_ack`: drop `mem_write`, pulse `cpu_done`, go to IDLE.
  - On `nxm`, or watchdog expiry: same as the read case, with `cpu_nxm`.
- RMW_HOLD:
  - `mem_addr` is retained and `cpu_ready`=0.
  - On `cpu_wb`: latch `cpu_wdata`, raise `mem_write`, reload the watchdog, go to RMW_WR.
  - No timeout is applied in this state.
- Acknowledge handling:
  - An acknowledge of the wrong kind (e.g. `write_ack` in RD) is ignored.
  - Acknowledges arriving in IDLE or RMW_HOLD (late acks after a timeout) are ignored.
  - If `nxm` and an ack arrive in the same cycle, `nxm` wins.
- Watchdog:
  - 10-bit down-counter.
  - Decrements each cycle a request is held.
  - Expiry = counter at 0 with no ack/nxm in that cycle.
- Reset (also mid-operation):
  - State goes to IDLE.
  - `mem_read`, `mem_write`, `cpu_done` and `cpu_nxm` go to 0.
  - `mem_addr`, `mem_write_data` and `cpu_rdata` go to 0; the watchdog goes to 0.
  - `cpu_ready` is 1 after the reset edge.

## Timing
- All outputs are registered; no combinational path from inputs to outputs.
- The request is raised on the accept edge E.
- The acknowledge is sampled at edge A, and the request is deasserted on that same edge A. `mem_read`/`mem_write` are therefore high from E+ through A.
- With a zero-wait responder, A = E+2. `cpu_done` is high in cycle E+2 to E+3.
- After any completion the block spends at least one cycle in IDLE or RMW_HOLD before raising a new request. This guarantees the responder's one-cycle post-ack recovery.
- Back-to-back READs: accepts at E and E+3, completions at E+2 and E+5.
- Watchdog expiry occurs `TIMEOUT`+1 edges after E.

## Structure
- `constants.vh` supplies `WORD` (36 bits) and `PADDR`/`PADDRSIZE`. Add there:
  - `MEM_OP_READ`, `MEM_OP_WRITE`, `MEM_OP_RMW` encodings.
  - The `WATCHDOG_BITS` width of 10.
- One natural sub-module, `mem_watchdog`, with ports:
  - `load` and `run` inputs, a load value, and an `expired` output.
- State encoding is local to `mem_initiator`.

## Test plan
- Zero-wait memory, READ at addr 0o1000 holding 0o123456701234:
  - `cpu_rdata`=0o123456701234 with `cpu_done` at E+2.
  - `mem_read` high exactly 2 cycles.
- WRITE 0o777777777777 to 0o2000, then READ 0o2000:
  - The read returns 0o777777777777.
  - `mem_read` and `mem_write` are never both high, and each gap between requests is ≥1 cycle.
- RMW at 0o3000 (holding 5):
  - Read completes and the bench waits 4 cycles in RMW_HOLD.
  - `cpu_wb` with data 6 drives `mem_write` with `mem_addr`=0o3000.
  - A final READ returns 6.
- Responder never acks, `TIMEOUT`=8:
  - `cpu_nxm` and `cpu_done` pulse at E+9.
  - `mem_read` drops at the same edge, and a late `read_ack` in IDLE is ignored.
- Responder `nxm` in the RMW read phase:
  - `cpu_nxm` pulses, state returns to IDLE, and no `mem_write` is ever raised.
- `reset` asserted while in WR with a 3-cycle-wait responder:
  - The next cycle has `mem_write`=0 and `cpu_ready`=1, with all outputs at their reset values.
